bcd_time_counter: RTL and testbench

Time-of-day counter that holds hours, minutes and seconds as BCD digit pairs. It is the stage directly upstream of the hr:min / min:sec display selector. It advances once per 1 Hz enable pulse. A set mode lets the user adjust hours and minutes with push-button pulses that are already debounced and single-cycle.

---
 rtl/bcd_time_counter.sv | 186 ++++++++++++++++++
 tb/tb_bcd_time_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// Time-of-day counter holding hh:mm:ss as BCD digit pairs, advanced by a 1 Hz enable.
// A SET state lets debounced push-button pulses adjust hours and minutes with seconds held at 00.
module bcd_time_counter #(
    parameter int TWELVE_HOUR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [3:0] second_ONES,
    output logic [3:0] second_TENS,
    output logic [3:0] min_ONES,
    output logic [3:0] min_TENS,
    output logic [3:0] hr_ONES,
    output logic [3:0] hr_TENS,
    output logic       day_wrap,
    output logic       in_set
);

    localparam bit       TWELVE      = (TWELVE_HOUR != 0);
    localparam logic [3:0] HR_RST_TENS = TWELVE ? 4'd1 : 4'd0;
    localparam logic [3:0] HR_RST_ONES = TWELVE ? 4'd2 : 4'd0;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] hr_ones_q,  hr_ones_d;
    logic [3:0] hr_tens_q,  hr_tens_d;
    logic       day_wrap_q, day_wrap_d;
    logic       in_set_q,   in_set_d;

    // Modulo-60 BCD increment; result is {carry, tens, ones}. Illegal input restarts at 00.
    function automatic logic [8:0] inc_base60(input logic [3:0] tens, input logic [3:0] ones);
        logic [8:0] res;
        if (tens > 4'd5 || ones > 4'd9) begin
            res = {1'b0, 4'd0, 4'd0};
        end else if (ones == 4'd9) begin
            if (tens == 4'd5) begin
                res = {1'b1, 4'd0, 4'd0};
            end else begin
                res = {1'b0, tens + 4'd1, 4'd0};
            end
        end else begin
            res = {1'b0, tens, ones + 4'd1};
        end
        return res;
    endfunction

    function automatic logic hour_legal(input logic [3:0] tens, input logic [3:0] ones);
        logic ok;
        if (TWELVE) begin
            ok = (tens == 4'd0 && ones >= 4'd1 && ones <= 4'd9) ||
                 (tens == 4'd1 && ones <= 4'd2);
        end else begin
            ok = (tens <= 4'd1 && ones <= 4'd9) ||
                 (tens == 4'd2 && ones <= 4'd3);
        end
        return ok;
    endfunction

    // Hour increment; result is {day_flag, tens, ones}. The flag marks the start of a new day
    // (23->00 on a 24-hour face, 11->12 on a 12-hour face).
    function automatic logic [8:0] inc_hour(input logic [3:0] tens, input logic [3:0] ones);
        logic [8:0] res;
        if (!hour_legal(tens, ones)) begin
            res = {1'b0, HR_RST_TENS, HR_RST_ONES};
        end else if (TWELVE) begin
            if (tens == 4'd1 && ones == 4'd2) begin
                res = {1'b0, 4'd0, 4'd1};
            end else if (tens == 4'd1 && ones == 4'd1) begin
                res = {1'b1, 4'd1, 4'd2};
            end else if (ones == 4'd9) begin
                res = {1'b0, 4'd1, 4'd0};
            end else begin
                res = {1'b0, tens, ones + 4'd1};
            end
        end else begin
            if (tens == 4'd2 && ones == 4'd3) begin
                res = {1'b1, 4'd0, 4'd0};
            end else if (ones == 4'd9) begin
                res = {1'b0, tens + 4'd1, 4'd0};
            end else begin
                res = {1'b0, tens, ones + 4'd1};
            end
        end
        return res;
    endfunction

    logic [8:0] sec_inc, min_inc, hr_inc;

    assign sec_inc = inc_base60(sec_tens_q, sec_ones_q);
    assign min_inc = inc_base60(min_tens_q, min_ones_q);
    assign hr_inc  = inc_hour(hr_tens_q, hr_ones_q);

    always_comb begin
        state_d    = state_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        hr_ones_d  = hr_ones_q;
        hr_tens_d  = hr_tens_q;
        day_wrap_d = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (set_mode) begin
                    // Entering SET clears seconds; tick and button pulses are dropped this edge.
                    state_d    = ST_SET;
                    sec_ones_d = 4'd0;
                    sec_tens_d = 4'd0;
                end else if (tick_1hz) begin
                    {sec_tens_d, sec_ones_d} = sec_inc[7:0];
                    if (sec_inc[8]) begin
                        {min_tens_d, min_ones_d} = min_inc[7:0];
                        if (min_inc[8]) begin
                            {hr_tens_d, hr_ones_d} = hr_inc[7:0];
                            day_wrap_d             = hr_inc[8];
                        end
                    end
                end
            end
            ST_SET: begin
                if (!set_mode) begin
                    state_d = ST_RUN;
                end
                sec_ones_d = 4'd0;
                sec_tens_d = 4'd0;
                if (inc_min) begin
                    {min_tens_d, min_ones_d} = min_inc[7:0];
                end
                if (inc_hr) begin
                    {hr_tens_d, hr_ones_d} = hr_inc[7:0];
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        in_set_d = (state_d == ST_SET);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            hr_ones_q  <= HR_RST_ONES;
            hr_tens_q  <= HR_RST_TENS;
            day_wrap_q <= 1'b0;
            in_set_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            hr_ones_q  <= hr_ones_d;
            hr_tens_q  <= hr_tens_d;
            day_wrap_q <= day_wrap_d;
            in_set_q   <= in_set_d;
        end
    end

    assign second_ONES = sec_ones_q;
    assign second_TENS = sec_tens_q;
    assign min_ONES    = min_ones_q;
    assign min_TENS    = min_tens_q;
    assign hr_ONES     = hr_ones_q;
    assign hr_TENS     = hr_tens_q;
    assign day_wrap    = day_wrap_q;
    assign in_set      = in_set_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench: stimulus pushes hand-computed expectations per cycle, monitor pops and compares.
// A 24-hour and a 12-hour instance share inputs; each entry names which one it checks.
module tb_bcd_time_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick_1hz = 1'b0;
    logic set_mode = 1'b0;
    logic inc_min = 1'b0;
    logic inc_hr = 1'b0;

    logic [3:0] a_so, a_st, a_mo, a_mt, a_ho, a_ht;
    logic       a_dw, a_is;
    logic [3:0] b_so, b_st, b_mo, b_mt, b_ho, b_ht;
    logic       b_dw, b_is;

    always #5 clk = ~clk;

    bcd_time_counter #(.TWELVE_HOUR(0)) u24 (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .set_mode(set_mode),
        .inc_min(inc_min), .inc_hr(inc_hr),
        .second_ONES(a_so), .second_TENS(a_st), .min_ONES(a_mo), .min_TENS(a_mt),
        .hr_ONES(a_ho), .hr_TENS(a_ht), .day_wrap(a_dw), .in_set(a_is)
    );

    bcd_time_counter #(.TWELVE_HOUR(1)) u12 (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .set_mode(set_mode),
        .inc_min(inc_min), .inc_hr(inc_hr),
        .second_ONES(b_so), .second_TENS(b_st), .min_ONES(b_mo), .min_TENS(b_mt),
        .hr_ONES(b_ho), .hr_TENS(b_ht), .day_wrap(b_dw), .in_set(b_is)
    );

    typedef struct packed {
        logic        ck;
        logic [23:0] t;
        logic        dw;
        logic        is;
        logic        d12;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input logic r, input logic t, input logic s, input logic im,
                        input logic ih, input logic ck, input logic [23:0] et,
                        input logic edw, input logic d12);
        exp_t e;
        rst      = r;
        tick_1hz = t;
        set_mode = s;
        inc_min  = im;
        inc_hr   = ih;
        e.ck  = ck;
        e.t   = et;
        e.dw  = edw;
        e.is  = r ? 1'b0 : s;
        e.d12 = d12;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every registered output is valid one edge after its stimulus.
    initial begin
        exp_t        e;
        logic [23:0] act_t;
        logic        act_dw, act_is;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.d12) begin
                    act_t  = {b_ht, b_ho, b_mt, b_mo, b_st, b_so};
                    act_dw = b_dw;
                    act_is = b_is;
                end else begin
                    act_t  = {a_ht, a_ho, a_mt, a_mo, a_st, a_so};
                    act_dw = a_dw;
                    act_is = a_is;
                end
                if (e.ck) begin
                    checks++;
                    if (act_t !== e.t) begin
                        errors++;
                        $display("FAIL time(d12=%0d) got %h expected %h at %0t", e.d12, act_t, e.t, $time);
                    end
                end
                checks++;
                if (act_dw !== e.dw) begin
                    errors++;
                    $display("FAIL day_wrap(d12=%0d) got %b expected %b at %0t", e.d12, act_dw, e.dw, $time);
                end
                checks++;
                if (act_is !== e.is) begin
                    errors++;
                    $display("FAIL in_set(d12=%0d) got %b expected %b at %0t", e.d12, act_is, e.is, $time);
                end
            end
        end
    end

    initial begin
        @(negedge clk);

        // 24-hour: reset, then minute and hour carries
        step(1, 0, 0, 0, 0, 1, 24'h000000, 0, 0);
        for (int i = 1; i <= 3600; i++) begin
            if (i == 59)        step(0, 1, 0, 0, 0, 1, 24'h000059, 0, 0);
            else if (i == 60)   step(0, 1, 0, 0, 0, 1, 24'h000100, 0, 0);
            else if (i == 3600) step(0, 1, 0, 0, 0, 1, 24'h010000, 0, 0);
            else                step(0, 1, 0, 0, 0, 0, 24'h000000, 0, 0);
        end

        // Preload 23:59:58 and cross midnight
        step(0, 0, 1, 0, 0, 1, 24'h010000, 0, 0);
        for (int i = 0; i < 59; i++)
            step(0, 0, 1, 1, (i < 22), (i == 58), 24'h235900, 0, 0);
        step(0, 0, 0, 0, 0, 1, 24'h235900, 0, 0);
        for (int i = 1; i <= 58; i++)
            step(0, 1, 0, 0, 0, (i == 58), 24'h235958, 0, 0);
        step(0, 1, 0, 0, 0, 1, 24'h235959, 0, 0);
        step(0, 1, 0, 0, 0, 1, 24'h000000, 1, 0);
        step(0, 0, 0, 0, 0, 1, 24'h000000, 0, 0);

        // Reach 10:20:37, enter SET with a tick on the same edge
        step(0, 0, 1, 0, 0, 1, 24'h000000, 0, 0);
        for (int i = 0; i < 20; i++)
            step(0, 0, 1, 1, (i < 10), (i == 19), 24'h102000, 0, 0);
        step(0, 0, 0, 0, 0, 1, 24'h102000, 0, 0);
        for (int i = 1; i <= 37; i++)
            step(0, 1, 0, 0, 0, (i == 37), 24'h102037, 0, 0);
        step(0, 1, 1, 0, 0, 1, 24'h102000, 0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 1, 1, 0, 0, 1, 24'h102000, 0, 0);
        for (int i = 1; i <= 40; i++) begin
            if (i == 39)      step(0, 0, 1, 1, 0, 1, 24'h105900, 0, 0);
            else if (i == 40) step(0, 0, 1, 1, 0, 1, 24'h100000, 0, 0);
            else              step(0, 0, 1, 1, 0, 0, 24'h000000, 0, 0);
        end
        for (int i = 1; i <= 14; i++) begin
            if (i == 13)      step(0, 0, 1, 0, 1, 1, 24'h230000, 0, 0);
            else if (i == 14) step(0, 0, 1, 0, 1, 1, 24'h000000, 0, 0);
            else              step(0, 0, 1, 0, 1, 0, 24'h000000, 0, 0);
        end

        // Simultaneous inc_min + inc_hr in SET; both ignored in RUN
        for (int i = 0; i < 30; i++)
            step(0, 0, 1, 1, (i < 5), (i == 29), 24'h053000, 0, 0);
        step(0, 0, 1, 1, 1, 1, 24'h063100, 0, 0);
        step(0, 0, 0, 0, 0, 1, 24'h063100, 0, 0);
        step(0, 0, 0, 1, 1, 1, 24'h063100, 0, 0);

        // Tick every cycle, reset wins over tick and set_mode
        step(1, 1, 0, 0, 0, 1, 24'h000000, 0, 0);
        for (int i = 1; i <= 100; i++)
            step(0, 1, 0, 0, 0, (i == 100), 24'h000140, 0, 0);
        step(1, 1, 1, 0, 0, 1, 24'h000000, 0, 0);
        step(0, 1, 0, 0, 0, 1, 24'h000001, 0, 0);
        step(0, 1, 0, 0, 0, 1, 24'h000002, 0, 0);

        // 12-hour instance
        step(1, 0, 0, 0, 0, 1, 24'h120000, 0, 1);
        step(0, 0, 1, 0, 0, 1, 24'h120000, 0, 1);
        for (int i = 0; i < 59; i++)
            step(0, 0, 1, 1, 0, (i == 58), 24'h125900, 0, 1);
        step(0, 0, 0, 0, 0, 1, 24'h125900, 0, 1);
        for (int i = 1; i <= 59; i++)
            step(0, 1, 0, 0, 0, (i == 59), 24'h125959, 0, 1);
        step(0, 1, 0, 0, 0, 1, 24'h010000, 0, 1);
        step(0, 0, 1, 0, 0, 1, 24'h010000, 0, 1);
        for (int i = 0; i < 59; i++)
            step(0, 0, 1, 1, (i < 10), (i == 58), 24'h115900, 0, 1);
        step(0, 0, 0, 0, 0, 1, 24'h115900, 0, 1);
        for (int i = 1; i <= 59; i++)
            step(0, 1, 0, 0, 0, (i == 59), 24'h115959, 0, 1);
        step(0, 1, 0, 0, 0, 1, 24'h120000, 1, 1);
        step(0, 0, 0, 0, 0, 1, 24'h120000, 0, 1);
        step(0, 0, 1, 0, 0, 1, 24'h120000, 0, 1);
        step(0, 0, 1, 0, 1, 1, 24'h010000, 0, 1);
        step(0, 0, 0, 0, 0, 1, 24'h010000, 0, 1);

        rst = 0; tick_1hz = 0; set_mode = 0; inc_min = 0; inc_hr = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
